// File: rtl/irq_gen_pkg.sv
// irq_gen_pkg: shared mode codes and channel state encoding for the interrupt pulse generator
package irq_gen_pkg;

    localparam logic [1:0] MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] MODE_PERIODIC = 2'b01;
    localparam logic [1:0] MODE_LEVEL    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_COUNT    = 2'b01,
        ST_PULSE    = 2'b10,
        ST_WAIT_ACK = 2'b11
    } ch_state_t;

endpackage

// File: rtl/irq_gen_channel.sv
// irq_gen_channel: one programmable interrupt source with delay, width and mode
module irq_gen_channel
    import irq_gen_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] delay,
    input  logic [CNT_W-1:0] width,
    input  logic             ack,
    output logic             irq
);

    ch_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_mode;
    logic [CNT_W-1:0] r_delay;
    logic [CNT_W-1:0] r_width;
    logic             r_irq;

    logic [CNT_W-1:0] w_arm_cnt;
    logic [CNT_W-1:0] w_reload_cnt;
    logic [CNT_W-1:0] w_pulse_cnt;

    // A programmed value of 0 behaves as 1, so the terminal count is max(x,1)-1
    assign w_arm_cnt    = (delay == '0) ? '0 : delay - CNT_W'(1);
    assign w_reload_cnt = (r_delay == '0) ? '0 : r_delay - CNT_W'(1);
    assign w_pulse_cnt  = (r_width == '0) ? '0 : r_width - CNT_W'(1);
    assign irq          = r_irq;

    // Channel FSM: a config write always overrides the internal transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_mode  <= MODE_ONESHOT;
            r_delay <= '0;
            r_width <= '0;
            r_irq   <= 1'b0;
        end else if (we) begin
            r_irq <= 1'b0;
            if (en) begin
                r_state <= ST_COUNT;
                r_cnt   <= w_arm_cnt;
                r_mode  <= (mode == 2'b11) ? MODE_ONESHOT : mode;
                r_delay <= delay;
                r_width <= width;
            end else begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end
        end else begin
            case (r_state)
                ST_COUNT: begin
                    if (r_cnt == '0) begin
                        r_state <= (r_mode == MODE_LEVEL) ? ST_WAIT_ACK : ST_PULSE;
                        r_cnt   <= (r_mode == MODE_LEVEL) ? '0 : w_pulse_cnt;
                        r_irq   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_PULSE: begin
                    if (r_cnt == '0) begin
                        r_state <= (r_mode == MODE_PERIODIC) ? ST_COUNT : ST_IDLE;
                        r_cnt   <= (r_mode == MODE_PERIODIC) ? w_reload_cnt : '0;
                        r_irq   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_WAIT_ACK: begin
                    if (ack) begin
                        r_state <= ST_IDLE;
                        r_irq   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/irq_pulse_gen.sv
// irq_pulse_gen: bank of programmable interrupt channels feeding the core interrupter input
module irq_pulse_gen
    import irq_gen_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    parameter int ID_W     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [ID_W-1:0]     cfg_ch,
    input  logic                cfg_en,
    input  logic [1:0]          cfg_mode,
    input  logic [CNT_W-1:0]    cfg_delay,
    input  logic [CNT_W-1:0]    cfg_width,
    input  logic [CHANNELS-1:0] ack,
    output logic [CHANNELS-1:0] irq,
    output logic                interrupter,
    output logic                irq_valid,
    output logic [ID_W-1:0]     irq_id
);

    logic [CHANNELS-1:0] w_we;
    logic [ID_W-1:0]     w_id;

    // Out-of-range channel indices match no instance, so those writes are dropped
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign w_we[c] = cfg_we && (cfg_ch == ID_W'(c));
        irq_gen_channel #(.CNT_W(CNT_W)) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (w_we[c]),
            .en    (cfg_en),
            .mode  (cfg_mode),
            .delay (cfg_delay),
            .width (cfg_width),
            .ack   (ack[c]),
            .irq   (irq[c])
        );
    end

    // Priority encoder: scanning downward leaves the lowest active index
    always_comb begin
        w_id = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (irq[i]) w_id = ID_W'(i);
        end
    end

    assign interrupter = |irq;
    assign irq_valid   = |irq;
    assign irq_id      = w_id;

endmodule

// File: tb/tb_irq_pulse_gen.sv
// tb_irq_pulse_gen: directed scoreboard bench for irq_pulse_gen
module tb_irq_pulse_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_ch = '0;
    logic        cfg_en = 1'b0;
    logic [1:0]  cfg_mode = '0;
    logic [15:0] cfg_delay = '0;
    logic [15:0] cfg_width = '0;
    logic [3:0]  ack = '0;
    logic [3:0]  irq;
    logic        interrupter;
    logic        irq_valid;
    logic [3:0]  irq_id;

    typedef struct {
        string      tag;
        logic [3:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    irq_pulse_gen #(.CHANNELS(4), .CNT_W(16), .ID_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_en      (cfg_en),
        .cfg_mode    (cfg_mode),
        .cfg_delay   (cfg_delay),
        .cfg_width   (cfg_width),
        .ack         (ack),
        .irq         (irq),
        .interrupter (interrupter),
        .irq_valid   (irq_valid),
        .irq_id      (irq_id)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] id_of(input logic [3:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = 3; i >= 0; i--) if (v[i]) r = 4'(i);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic plan(input string tag, input logic [3:0] v, input int n);
        repeat (n) sb.push_back('{tag, v});
    endtask

    task automatic run_all();
        while (sb.size() > 0) begin
            exp_t e;
            @(negedge clk);
            e = sb.pop_front();
            chk(e.tag, {irq, interrupter, irq_valid, irq_id}, {e.v, |e.v, |e.v, id_of(e.v)});
        end
    endtask

    task automatic wr(input logic [3:0] ch, input logic en, input logic [1:0] mode,
                      input logic [15:0] d, input logic [15:0] w);
        cfg_ch = ch; cfg_en = en; cfg_mode = mode; cfg_delay = d; cfg_width = w; cfg_we = 1'b1;
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    task automatic ack_pulse(input int ch);
        ack[ch] = 1'b1;
        @(posedge clk);
        #1 ack = '0;
    endtask

    initial begin
        plan("reset_hold", 4'b0000, 3);
        run_all();
        rst_n = 1'b1;
        plan("post_reset", 4'b0000, 3);
        run_all();

        wr(4'd0, 1'b1, 2'b00, 16'd15, 16'd1);
        plan("oneshot_delay", 4'b0000, 15);
        plan("oneshot_pulse", 4'b0001, 1);
        plan("oneshot_after", 4'b0000, 3);
        run_all();

        wr(4'd0, 1'b1, 2'b10, 16'd2, 16'd0);
        plan("pre_reset_cnt", 4'b0000, 2);
        plan("pre_reset_hi", 4'b0001, 3);
        run_all();
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {irq, interrupter, irq_valid, irq_id}, 10'd0);
        @(negedge clk);
        rst_n = 1'b1;
        plan("after_reset_50", 4'b0000, 50);
        run_all();

        wr(4'd1, 1'b1, 2'b01, 16'd10, 16'd2);
        for (int p = 0; p < 2; p++) begin
            plan("periodic_gap", 4'b0000, 10);
            plan("periodic_pulse", 4'b0010, 2);
        end
        plan("periodic_gap", 4'b0000, 10);
        plan("periodic_pulse", 4'b0010, 1);
        run_all();
        wr(4'd1, 1'b0, 2'b01, 16'd10, 16'd2);
        plan("disarm", 4'b0000, 30);
        run_all();

        wr(4'd2, 1'b1, 2'b10, 16'd5, 16'd0);
        plan("level_cnt", 4'b0000, 5);
        plan("level_hold", 4'b0100, 20);
        run_all();
        ack_pulse(2);
        plan("level_acked", 4'b0000, 5);
        run_all();
        ack_pulse(2);
        plan("ack_idle", 4'b0000, 3);
        run_all();

        wr(4'd3, 1'b1, 2'b10, 16'd2, 16'd0);
        wr(4'd1, 1'b1, 2'b10, 16'd2, 16'd0);
        plan("prio_none", 4'b0000, 1);
        plan("prio_ch3", 4'b1000, 1);
        plan("prio_both", 4'b1010, 2);
        run_all();
        ack_pulse(1);
        plan("prio_ch3_only", 4'b1000, 2);
        run_all();
        ack_pulse(3);
        plan("prio_none_end", 4'b0000, 2);
        run_all();

        wr(4'd0, 1'b1, 2'b00, 16'd0, 16'd0);
        plan("zero_delay", 4'b0000, 1);
        plan("zero_width", 4'b0001, 1);
        plan("zero_after", 4'b0000, 2);
        run_all();

        wr(4'd4, 1'b1, 2'b10, 16'd1, 16'd1);
        plan("bad_channel", 4'b0000, 5);
        run_all();

        wr(4'd0, 1'b1, 2'b00, 16'd3, 16'd4);
        plan("rearm_cnt", 4'b0000, 3);
        plan("rearm_old", 4'b0001, 2);
        run_all();
        wr(4'd0, 1'b1, 2'b00, 16'd3, 16'd4);
        plan("rearm_drop", 4'b0000, 3);
        plan("rearm_new", 4'b0001, 4);
        plan("rearm_end", 4'b0000, 2);
        run_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
